// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - round-robin SPI A2D conversion scheduler
//
// Converts channels 0, 4, 5, 6 in turn on each accepted nxt request. Every
// conversion is two identical 16-bit SPI frames separated by a short gap.
// The first frame's read data is discarded. The low 12 bits of the second
// frame's read data go to the result register of the active channel.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   nxt               request to convert the next channel
//   busy, cnv_cmplt   conversion in progress / result-updated pulse
//   lft_ld, rght_ld,  latest results for channels 0, 4, 5, 6
//   steer_pot, batt
//   SS_n, SCLK, MOSI  SPI master outputs (SCLK idles high)
//   MISO              SPI data from the A2D
module a2d_sched #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        busy,
  output logic        cnv_cmplt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF    = SCLK_DIV / 2;
  localparam int FRM_LEN = 16 * SCLK_DIV + HALF + 1;
  localparam int CW      = $clog2(FRM_LEN);
  localparam int LD      = $clog2(SCLK_DIV);

  localparam logic [CW-1:0] FRM_LAST = CW'(FRM_LEN - 1);
  localparam logic [CW-1:0] HALF_C   = CW'(HALF);
  localparam logic [CW-1:0] BITS_END = CW'(16 * SCLK_DIV);

  typedef enum logic [2:0] {IDLE, FRM1, GAP, FRM2, UPD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rr_q, rr_d;
  logic [2:0]    ch_q, ch_d;
  logic [11:0]   rx_q, rx_d;
  logic [11:0]   res_q [4];
  logic          ss_n_q, sclk_q, mosi_q;
  logic          ss_n_d, sclk_d, mosi_d;
  logic [CW-1:0] pos_q, pos_d, sh_d;
  logic [15:0]   cmd_d;
  logic [3:0]    bit_idx;
  logic          act_q, act_d, rise, upd_en;

  // Each frame state lasts FRM_LEN cycles, but SS_n is low for only
  // 16*SCLK_DIV+1 of them. The spare half period is placed before the first
  // frame and after the second frame. This keeps SS_n high for exactly the
  // two GAP cycles between the frames. pos is the cycle offset from the
  // SS_n falling edge.
  function automatic logic [CW-1:0] frame_pos(state_t s, logic [CW-1:0] c);
    return (s == FRM1) ? c - HALF_C : c;
  endfunction

  function automatic logic in_window(state_t s, logic [CW-1:0] c);
    if (s == FRM1) return c >= HALF_C;
    if (s == FRM2) return c <= BITS_END;
    return 1'b0;
  endfunction

  // Sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: if (nxt) begin
        state_d = FRM1;
        cnt_d   = '0;
        case (rr_q)
          2'd0:    ch_d = 3'd0;
          2'd1:    ch_d = 3'd4;
          2'd2:    ch_d = 3'd5;
          default: ch_d = 3'd6;
        endcase
      end
      FRM1: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FRM_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = FRM2;
          cnt_d   = '0;
        end
      end
      FRM2: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FRM_LAST) begin
          state_d = UPD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        rr_d    = rr_q + 2'd1;
      end
    endcase
  end

  // SPI pins are registered from the next state, so they line up exactly
  // with the state/counter registers and cannot glitch.
  always_comb begin
    pos_d   = frame_pos(state_d, cnt_d);
    act_d   = in_window(state_d, cnt_d);
    sh_d    = pos_d - HALF_C;
    bit_idx = 4'd15 - 4'(sh_d >> LD);
    cmd_d   = {2'b00, ch_d, 11'h000};
    ss_n_d  = ~act_d;
    sclk_d  = ~(act_d && (pos_d < BITS_END) && pos_d[LD-1]);
    mosi_d  = act_d && (pos_d >= HALF_C) && cmd_d[bit_idx];
  end

  // A rising SCLK edge is visible on the pin in cycles where pos is a
  // nonzero multiple of SCLK_DIV. MISO is captured at the end of that cycle.
  always_comb begin
    pos_q  = frame_pos(state_q, cnt_q);
    act_q  = in_window(state_q, cnt_q);
    rise   = act_q && (pos_q != '0) && (pos_q[LD-1:0] == '0);
    rx_d   = rise ? {rx_q[10:0], MISO} : rx_q;
    upd_en = (state_q == FRM2) && (cnt_q == FRM_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      ch_q    <= '0;
      rx_q    <= '0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      rx_q    <= rx_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      // Written on entry to UPD so the new value is visible while cnv_cmplt is high
      if (upd_en) res_q[rr_q] <= rx_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign cnv_cmplt = (state_q == UPD);
  assign lft_ld    = res_q[0];
  assign rght_ld   = res_q[1];
  assign steer_pot = res_q[2];
  assign batt      = res_q[3];
  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_a2d_sched.sv
// tb/tb_a2d_sched.sv - testbench for a2d_sched
module tb_a2d_sched;
  localparam int D    = 32;
  localparam int HALF = D / 2;
  localparam int LAT  = 2 * (16 * D + HALF + 1) + 2 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        nxt = 1'b0;
  logic        MISO = 1'b0;
  logic        busy, cnv_cmplt, SS_n, SCLK, MOSI;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  a2d_sched #(.SCLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .busy(busy), .cnv_cmplt(cnv_cmplt),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: round-robin pointer, channel map, expected result registers
  int          rr_m = 0;
  int          chan_of [4] = '{0, 4, 5, 6};
  logic [11:0] exp_res [4];
  logic [11:0] ch_val [8];

  // Observations from the last conversion
  int          obs_lat;
  logic        obs_busy1, obs_busy_after, obs_cmplt_after;
  logic [11:0] obs_res [4];
  logic [15:0] cmd_q [$];

  // A2D model: latches the channel from each frame's command, and returns
  // the previously commanded channel's value (random upper nibble) on the
  // next frame. Shifts on SCLK falls.
  logic [15:0] a2d_tx, a2d_rx;
  int          a2d_fc;
  logic [2:0]  a2d_last_ch = 3'd0;

  always @(negedge SS_n) begin
    a2d_fc = 0;
    a2d_tx = {4'($urandom), ch_val[a2d_last_ch]};
  end
  always @(negedge SCLK) if (!SS_n && a2d_fc < 16) begin
    MISO = a2d_tx[15 - a2d_fc];
    a2d_fc++;
  end
  always @(posedge SCLK) if (!SS_n) a2d_rx = {a2d_rx[14:0], MOSI};
  always @(posedge SS_n) a2d_last_ch = a2d_rx[13:11];

  // Protocol monitor, sampled on the falling clock edge
  logic        p_ss = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;
  int          t, rises, last_rise, hi_cnt, frames;
  logic        in_frame = 1'b0, first_fall = 1'b0;
  logic [15:0] cmd_sh;

  always @(negedge clk) begin
    if (!rst_n) begin
      frames = 0; in_frame = 1'b0; hi_cnt = 0;
    end else begin
      n_cmp++;
      if (SS_n && (SCLK !== 1'b1 || MOSI !== 1'b0)) begin
        n_err++; $display("FAIL idle_pins: SCLK=%b MOSI=%b with SS_n high, want 1/0", SCLK, MOSI);
      end
      n_cmp++;
      if (MOSI !== p_mosi && !(p_sclk && !SCLK)) begin
        n_err++; $display("FAIL mosi_edge: MOSI %b->%b without SCLK fall, want stable", p_mosi, MOSI);
      end
      if (p_ss && !SS_n) begin
        if (frames == 1) begin
          n_cmp++;
          if (hi_cnt != 2) begin n_err++; $display("FAIL gap: %0d cycles, want 2", hi_cnt); end
        end
        t = 0; rises = 0; first_fall = 1'b1; in_frame = 1'b1;
      end else if (in_frame) t++;
      if (!SS_n && p_sclk && !SCLK && first_fall) begin
        n_cmp++;
        if (t != HALF) begin n_err++; $display("FAIL first_fall: %0d cycles, want %0d", t, HALF); end
        first_fall = 1'b0;
      end
      if (!SS_n && !p_sclk && SCLK) begin
        rises++; last_rise = t; cmd_sh = {cmd_sh[14:0], MOSI};
      end
      if (!p_ss && SS_n && in_frame) begin
        n_cmp++;
        if (rises != 16) begin n_err++; $display("FAIL rises: %0d per frame, want 16", rises); end
        n_cmp++;
        if (t - last_rise != 1) begin
          n_err++; $display("FAIL ss_rise: %0d cycles after last rise, want 1", t - last_rise);
        end
        cmd_q.push_back(cmd_sh);
        frames++; in_frame = 1'b0; hi_cnt = 1;
      end else if (SS_n) hi_cnt++;
      if (cnv_cmplt) frames = 0;
    end
    p_ss = SS_n; p_sclk = SCLK; p_mosi = MOSI;
  end

  task automatic do_conversion();
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    obs_lat = 1; obs_busy1 = busy;
    while (!cnv_cmplt && obs_lat < LAT + 50) begin @(negedge clk); obs_lat++; end
    obs_res[0] = lft_ld; obs_res[1] = rght_ld; obs_res[2] = steer_pot; obs_res[3] = batt;
    @(negedge clk);
    obs_busy_after = busy; obs_cmplt_after = cnv_cmplt;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || cnv_cmplt !== 1'b0) begin
      n_err++; $display("FAIL reset_ctl: busy=%b cnv_cmplt=%b, want 0/0", busy, cnv_cmplt);
    end
    n_cmp++;
    if (SS_n !== 1'b1 || SCLK !== 1'b1 || MOSI !== 1'b0) begin
      n_err++; $display("FAIL reset_pins: SS_n=%b SCLK=%b MOSI=%b, want 1/1/0", SS_n, SCLK, MOSI);
    end
    n_cmp++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
      n_err++; $display("FAIL reset_regs: %h %h %h %h, want all 000", lft_ld, rght_ld, steer_pot, batt);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    for (int i = 0; i < 4; i++) exp_res[i] = 12'h000;
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_cmd;
    int ch;
    ch_val[0] = 12'h156; ch_val[4] = 12'h2A0; ch_val[5] = 12'h100; ch_val[6] = 12'h900;
    for (int k = 0; k < 5; k++) begin
      ch = chan_of[rr_m];
      exp_cmd = 16'(ch << 11);
      cmd_q.delete();
      do_conversion();
      exp_res[rr_m] = ch_val[ch];
      rr_m = (rr_m + 1) % 4;
      n_cmp++;
      if (obs_lat != LAT) begin n_err++; $display("FAIL rr_latency: ch%0d %0d, want %0d", ch, obs_lat, LAT); end
      n_cmp++;
      if (obs_busy1 !== 1'b1) begin n_err++; $display("FAIL rr_busy: %b, want 1", obs_busy1); end
      n_cmp++;
      if (obs_busy_after !== 1'b0 || obs_cmplt_after !== 1'b0) begin
        n_err++; $display("FAIL rr_idle_after: busy=%b cmplt=%b, want 0/0", obs_busy_after, obs_cmplt_after);
      end
      n_cmp++;
      if (cmd_q.size() != 2) begin
        n_err++; $display("FAIL rr_frames: %0d frames, want 2", cmd_q.size());
      end else begin
        for (int f = 0; f < 2; f++) begin
          n_cmp++;
          if (cmd_q[f] !== exp_cmd) begin
            n_err++; $display("FAIL rr_cmd: frame%0d %h, want %h", f, cmd_q[f], exp_cmd);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_res[i] !== exp_res[i]) begin
          n_err++; $display("FAIL rr_result: conv%0d reg%0d %h, want %h", k, i, obs_res[i], exp_res[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_pulse = 0;
    int n_low = 0;
    int lat = 0;
    ch_val[chan_of[rr_m]] = 12'($urandom);
    cmd_q.delete();
    @(negedge clk); nxt = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); lat++;
      if (cnv_cmplt) n_pulse++;
    end
    nxt = 1'b0;
    while (!cnv_cmplt && lat < LAT + 50) begin @(negedge clk); lat++; end
    if (cnv_cmplt) n_pulse++;
    obs_res[0] = lft_ld; obs_res[1] = rght_ld; obs_res[2] = steer_pot; obs_res[3] = batt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cnv_cmplt) n_pulse++;
      if (!SS_n || busy) n_low++;
    end
    exp_res[rr_m] = ch_val[chan_of[rr_m]];
    rr_m = (rr_m + 1) % 4;
    n_cmp++;
    if (lat != LAT) begin n_err++; $display("FAIL b2b_latency: %0d, want %0d", lat, LAT); end
    n_cmp++;
    if (n_pulse != 1) begin n_err++; $display("FAIL b2b_pulses: %0d cnv_cmplt, want 1", n_pulse); end
    n_cmp++;
    if (n_low != 0) begin n_err++; $display("FAIL b2b_restart: %0d active cycles after, want 0", n_low); end
    n_cmp++;
    if (cmd_q.size() != 2) begin n_err++; $display("FAIL b2b_frames: %0d, want 2", cmd_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_res[i] !== exp_res[i]) begin
        n_err++; $display("FAIL b2b_result: reg%0d %h, want %h", i, obs_res[i], exp_res[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int falls = 0;
    int cyc = 0;
    logic prev = 1'b1;
    n_cmp++;
    if (steer_pot !== 12'h100) begin n_err++; $display("FAIL pre_abort: steer_pot %h, want 100", steer_pot); end
    n_cmp++;
    if (chan_of[rr_m] != 5) begin n_err++; $display("FAIL pre_abort_rr: next ch%0d, want 5", chan_of[rr_m]); end
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    while (falls < 2 && cyc < LAT + 50) begin
      @(negedge clk); cyc++;
      if (prev && !SS_n) falls++;
      prev = SS_n;
    end
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (falls != 2) begin n_err++; $display("FAIL abort_setup: %0d frames seen, want 2", falls); end
    n_cmp++;
    if (SS_n !== 1'b1 || SCLK !== 1'b1 || MOSI !== 1'b0) begin
      n_err++; $display("FAIL abort_pins: SS_n=%b SCLK=%b MOSI=%b, want 1/1/0", SS_n, SCLK, MOSI);
    end
    n_cmp++;
    if (steer_pot !== 12'h000 || {lft_ld, rght_ld, batt} !== 36'h0) begin
      n_err++; $display("FAIL abort_regs: %h %h %h %h, want all 000", lft_ld, rght_ld, steer_pot, batt);
    end
    n_cmp++;
    if (busy !== 1'b0 || cnv_cmplt !== 1'b0) begin
      n_err++; $display("FAIL abort_ctl: busy=%b cmplt=%b, want 0/0", busy, cnv_cmplt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    for (int i = 0; i < 4; i++) exp_res[i] = 12'h000;
    cmd_q.delete();
    ch_val[0] = 12'($urandom);
    do_conversion();
    exp_res[0] = ch_val[0];
    rr_m = 1;
    n_cmp++;
    if (obs_lat != LAT) begin n_err++; $display("FAIL post_abort_latency: %0d, want %0d", obs_lat, LAT); end
    n_cmp++;
    if (cmd_q.size() != 2 || cmd_q[0] !== 16'h0000) begin
      n_err++; $display("FAIL post_abort_cmd: %0d frames, first %h, want 2 frames of 0000",
                        cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 16'hxxxx);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_res[i] !== exp_res[i]) begin
        n_err++; $display("FAIL post_abort_result: reg%0d %h, want %h", i, obs_res[i], exp_res[i]);
      end
    end
  endtask

  task automatic test_random();
    int ch;
    for (int k = 0; k < 8; k++) begin
      ch = chan_of[rr_m];
      ch_val[ch] = (k == 0) ? 12'hFFF : (k == 1) ? 12'h000 : 12'($urandom);
      cmd_q.delete();
      // Idle gap of random length before the request
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_conversion();
      exp_res[rr_m] = ch_val[ch];
      rr_m = (rr_m + 1) % 4;
      n_cmp++;
      if (obs_lat != LAT) begin n_err++; $display("FAIL rand_latency: ch%0d %0d, want %0d", ch, obs_lat, LAT); end
      n_cmp++;
      if (cmd_q.size() != 2 || cmd_q[1] !== 16'(ch << 11)) begin
        n_err++; $display("FAIL rand_cmd: %0d frames, want 2 of %h", cmd_q.size(), 16'(ch << 11));
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_res[i] !== exp_res[i]) begin
          n_err++; $display("FAIL rand_result: conv%0d reg%0d %h, want %h", k, i, obs_res[i], exp_res[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ch_val[i] = 12'h000;
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
